// File: rtl/rob_commit_unit.sv
// Retirement stage at the ROB head: commits completed entries in order to the
// register file and turns a faulting head into a one-cycle flush plus fetch redirect.
module rob_commit_unit #(
  parameter int              XLEN       = 32,
  parameter int              IDX_W      = 4,
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(32'h0000_2000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             head_valid,
  input  logic             head_ready,
  input  logic [IDX_W-1:0] head_idx,
  input  logic [XLEN-1:0]  head_PC,
  input  logic [XLEN-1:0]  head_value,
  input  logic [4:0]       head_rd,
  input  logic             head_we,
  input  logic [2:0]       head_exc,
  input  logic [XLEN-1:0]  head_addr_miss,
  input  logic             commit_stall,
  input  logic             redirect_ready,
  output logic             commit_pop,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_PC,
  output logic [XLEN-1:0]  exc_PC,
  output logic [XLEN-1:0]  exc_addr,
  output logic [1:0]       exc_cause,
  output logic [IDX_W-1:0] exc_idx,
  output logic [31:0]      retired_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       can_retire;
  logic       has_exc;
  logic       exc_take;
  logic [1:0] cause_d;

  // A stalled head is neither committed nor allowed to raise its exception.
  assign can_retire = head_valid & head_ready & ~commit_stall;
  assign has_exc    = |head_exc;

  // Lowest-numbered exception bit wins.
  always_comb begin
    if (head_exc[0])      cause_d = 2'd1;
    else if (head_exc[1]) cause_d = 2'd2;
    else if (head_exc[2]) cause_d = 2'd3;
    else                  cause_d = 2'd0;
  end

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_d unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (can_retire && has_exc) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Output decode; commit_pop is forced low while reset is asserted.
  always_comb begin
    commit_pop     = 1'b0;
    exc_take       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_PC    = '0;
    case (state_q)
      ST_RUN: begin
        commit_pop = reset & can_retire & ~has_exc;
        exc_take   = reset & can_retire & has_exc;
      end
      ST_FLUSH:    flush = 1'b1;
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_PC    = EXC_VECTOR;
      end
      default: ;
    endcase
  end

  // Register-file write port: valid only in the cycle after a retirement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= commit_pop & head_we & (head_rd != 5'd0);
      if (commit_pop) begin
        rf_waddr <= head_rd;
        rf_wdata <= head_value;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          retired_count <= '0;
    else if (commit_pop) retired_count <= retired_count + 32'd1;
  end

  // Exception record survives the return to RUN until the next fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_PC    <= '0;
      exc_addr  <= '0;
      exc_cause <= 2'd0;
      exc_idx   <= '0;
    end else if (exc_take) begin
      exc_PC    <= head_PC;
      exc_addr  <= head_addr_miss;
      exc_cause <= cause_d;
      exc_idx   <= head_idx;
    end
  end

endmodule
